// File: rtl/wb_bpm_swap_cfg_master_if.sv
// rtl/wb_bpm_swap_cfg_master_if.sv - Wishbone classic bus bundle between the cfg master and the swap slave
interface wb_bpm_swap_cfg_master_if;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic        ack;

   modport master (output adr, dat_w, cyc, stb, we, sel, input dat_r, ack);
   modport slave  (input adr, dat_w, cyc, stb, we, sel, output dat_r, ack);
endinterface

// File: rtl/wb_bpm_swap_cfg_master.sv
// rtl/wb_bpm_swap_cfg_master.sv - Wishbone master programming a wb_bpm_swap slave; optional WB_SWAP_CFG_READBACK_EN verifies each init write
module wb_bpm_swap_cfg_master #(
   parameter logic [31:0] G_BASE_ADDR = 32'h0,
   parameter int          G_TIMEOUT   = 255
) (
   input  logic        clk_sys_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        mode_upd_i,
   input  logic [1:0]  mode1_i,
   input  logic [1:0]  mode2_i,
   input  logic [15:0] swap_div_f_i,
   input  logic [15:0] dly1_i,
   input  logic [15:0] dly2_i,
   input  logic [39:0] gain_dir_i,
   input  logic [39:0] gain_crs_i,
   wb_bpm_swap_cfg_master_if.master wb,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] err_adr_o
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_ACK = 2'd1;
   localparam logic [1:0] ST_GAP      = 2'd2;
   localparam logic [1:0] ST_MODIFY   = 2'd3;

   localparam logic [15:0] TMAX = 16'(G_TIMEOUT - 1);

   logic [1:0]  state;
   logic        op_rmw;
   logic [2:0]  idx;
   logic [15:0] tcnt;
   logic [31:0] rd_q;
   logic [1:0]  mode1_q, mode2_q;
   logic [15:0] div_q, dly1_q, dly2_q;
   logic [39:0] gdir_q, gcrs_q;
   logic [7:0]  off;
   logic [31:0] wdat;
`ifdef WB_SWAP_CFG_READBACK_EN
   logic        rb_pend;
   logic [31:0] fmask;
`endif

   assign wb.sel = 4'hF;

   // Address offset and write data of init step idx, built from the latched inputs
   always_comb begin
      off  = 8'h00;
      wdat = {8'h00, div_q, 3'b000, mode2_q, mode1_q, 1'b0};
      case (idx)
         3'd0: begin off = 8'h04; wdat = {dly2_q, dly1_q}; end
         3'd1: begin off = 8'h08; wdat = {6'h0, gcrs_q[9:0],   6'h0, gdir_q[9:0]};   end
         3'd2: begin off = 8'h0C; wdat = {6'h0, gcrs_q[19:10], 6'h0, gdir_q[19:10]}; end
         3'd3: begin off = 8'h10; wdat = {6'h0, gcrs_q[29:20], 6'h0, gdir_q[29:20]}; end
         3'd4: begin off = 8'h14; wdat = {6'h0, gcrs_q[39:30], 6'h0, gdir_q[39:30]}; end
         default: ;
      endcase
   end

`ifdef WB_SWAP_CFG_READBACK_EN
   // Only defined field bits of each register take part in the readback compare
   always_comb begin
      fmask = 32'h00FF_FF1E;
      case (idx)
         3'd0:                      fmask = 32'hFFFF_FFFF;
         3'd1, 3'd2, 3'd3, 3'd4:    fmask = 32'h03FF_03FF;
         default: ;
      endcase
   end
`endif

   // Sequencer: issues one Wishbone transaction at a time with an idle cycle between them
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         wb.cyc    <= 1'b0;
         wb.stb    <= 1'b0;
         wb.we     <= 1'b0;
         wb.adr    <= '0;
         wb.dat_w  <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         err_adr_o <= '0;
         op_rmw    <= 1'b0;
         idx       <= '0;
         tcnt      <= '0;
         rd_q      <= '0;
         mode1_q   <= '0;
         mode2_q   <= '0;
         div_q     <= '0;
         dly1_q    <= '0;
         dly2_q    <= '0;
         gdir_q    <= '0;
         gcrs_q    <= '0;
`ifdef WB_SWAP_CFG_READBACK_EN
         rb_pend   <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i || mode_upd_i) begin
                  mode1_q <= mode1_i;
                  mode2_q <= mode2_i;
                  div_q   <= swap_div_f_i;
                  dly1_q  <= dly1_i;
                  dly2_q  <= dly2_i;
                  gdir_q  <= gain_dir_i;
                  gcrs_q  <= gain_crs_i;
                  err_o   <= 1'b0;
                  busy_o  <= 1'b1;
                  idx     <= '0;
                  tcnt    <= '0;
                  op_rmw  <= ~start_i;
                  wb.cyc  <= 1'b1;
                  wb.stb  <= 1'b1;
                  state   <= ST_WAIT_ACK;
`ifdef WB_SWAP_CFG_READBACK_EN
                  rb_pend <= 1'b0;
`endif
                  // The first transaction goes out straight from the inputs to save a cycle
                  if (start_i) begin
                     wb.adr   <= G_BASE_ADDR + 32'h4;
                     wb.dat_w <= {dly2_i, dly1_i};
                     wb.we    <= 1'b1;
                  end else begin
                     wb.adr   <= G_BASE_ADDR;
                     wb.dat_w <= '0;
                     wb.we    <= 1'b0;
                  end
               end
            end
            ST_WAIT_ACK: begin
               if (wb.ack) begin
                  wb.cyc <= 1'b0;
                  wb.stb <= 1'b0;
                  tcnt   <= '0;
                  if (op_rmw) begin
                     if (!wb.we) begin
                        rd_q  <= wb.dat_r;
                        state <= ST_MODIFY;
                     end else begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                     end
                  end
`ifdef WB_SWAP_CFG_READBACK_EN
                  else if (wb.we) begin
                     rb_pend <= 1'b1;
                     state   <= ST_GAP;
                  end else if (((wb.dat_r ^ wdat) & fmask) != 32'h0) begin
                     err_o     <= 1'b1;
                     err_adr_o <= wb.adr;
                     busy_o    <= 1'b0;
                     state     <= ST_IDLE;
                  end
`endif
                  else if (idx == 3'd5) begin
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     state  <= ST_IDLE;
                  end else begin
                     idx   <= idx + 3'd1;
                     state <= ST_GAP;
                  end
               end else if (tcnt == TMAX) begin
                  wb.cyc    <= 1'b0;
                  wb.stb    <= 1'b0;
                  err_o     <= 1'b1;
                  err_adr_o <= wb.adr;
                  busy_o    <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            ST_GAP: begin
               wb.cyc <= 1'b1;
               wb.stb <= 1'b1;
               tcnt   <= '0;
               wb.adr <= G_BASE_ADDR + {24'h0, off};
               state  <= ST_WAIT_ACK;
`ifdef WB_SWAP_CFG_READBACK_EN
               wb.we    <= ~rb_pend;
               wb.dat_w <= rb_pend ? 32'h0 : wdat;
               rb_pend  <= 1'b0;
`else
               wb.we    <= 1'b1;
               wb.dat_w <= wdat;
`endif
            end
            ST_MODIFY: begin
               // Replace only the mode fields [4:1] of the value read back
               wb.adr   <= G_BASE_ADDR;
               wb.dat_w <= {rd_q[31:5], mode2_q, mode1_q, rd_q[0]};
               wb.we    <= 1'b1;
               wb.cyc   <= 1'b1;
               wb.stb   <= 1'b1;
               tcnt     <= '0;
               state    <= ST_WAIT_ACK;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_bpm_swap_cfg_master.sv
// tb/tb_wb_bpm_swap_cfg_master.sv - directed self-checking bench for wb_bpm_swap_cfg_master
module tb_wb_bpm_swap_cfg_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mode_upd = 1'b0;
   logic [1:0]  mode1 = 2'b00;
   logic [1:0]  mode2 = 2'b00;
   logic [15:0] div_f = 16'h0;
   logic [15:0] dly1 = 16'h0;
   logic [15:0] dly2 = 16'h0;
   logic [39:0] gain_dir = 40'h0;
   logic [39:0] gain_crs = 40'h0;
   logic        busy, done, err;
   logic [31:0] err_adr;

   logic        noack08 = 1'b0;
   logic        corrupt08 = 1'b0;
   logic        ctrl_ovr = 1'b0;
   logic [31:0] ctrl_val = 32'h0;
   logic [31:0] mem [0:7];
   logic [31:0] wlog_adr [$];
   logic [31:0] wlog_dat [$];
   logic [31:0] rlog_adr [$];

   int n_tests = 0;
   int n_fail  = 0;

   wb_bpm_swap_cfg_master_if bus();

   wb_bpm_swap_cfg_master #(.G_BASE_ADDR(32'h0), .G_TIMEOUT(16)) dut (
      .clk_sys_i    (clk),
      .rst_i        (rst),
      .start_i      (start),
      .mode_upd_i   (mode_upd),
      .mode1_i      (mode1),
      .mode2_i      (mode2),
      .swap_div_f_i (div_f),
      .dly1_i       (dly1),
      .dly2_i       (dly2),
      .gain_dir_i   (gain_dir),
      .gain_crs_i   (gain_crs),
      .wb           (bus.master),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .err_adr_o    (err_adr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      if (a == 32'h0 && ctrl_ovr)  return ctrl_val;
      if (a == 32'h8 && corrupt08) return 32'h0007_0004;
      return mem[a[4:2]];
   endfunction

   // Slave model: acks on the 2nd strobe cycle, logs every completed transfer
   always @(posedge clk) begin
      if (rst) begin
         bus.ack <= 1'b0;
         bus.dat_r <= 32'h0;
         for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      end else begin
         if (bus.cyc && bus.stb && !bus.ack && !(noack08 && bus.adr == 32'h8)) begin
            bus.ack   <= 1'b1;
            bus.dat_r <= rd_val(bus.adr);
         end else begin
            bus.ack <= 1'b0;
         end
         if (bus.cyc && bus.stb && bus.ack) begin
            if (bus.we) begin
               mem[bus.adr[4:2]] <= bus.dat_w;
               wlog_adr.push_back(bus.adr);
               wlog_dat.push_back(bus.dat_w);
            end else begin
               rlog_adr.push_back(bus.adr);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one accepted sequence (pulse already driven) until busy falls
   task automatic run_seq(input int maxc, input int restart_at,
                          output int done_cyc, output int n_done, output int stb08);
      done_cyc = -1;
      n_done   = 0;
      stb08    = 0;
      for (int c = 1; c <= maxc; c++) begin
         @(negedge clk);
         if (c == 1) begin start = 1'b0; mode_upd = 1'b0; end
         if (c == restart_at) start = 1'b1;
         if (c == restart_at + 1) start = 1'b0;
         if (bus.stb && bus.adr == 32'h8) stb08++;
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (!busy) break;
      end
      check("seq_bound_busy", {31'h0, busy}, 32'h0);
   endtask

   int dc, nd, s08, w0, r0;
   logic [31:0] exp_w [0:5];

   initial begin
      exp_w[0] = 32'h0008_0002; exp_w[1] = 32'h0007_0003; exp_w[2] = 32'h0001_0001;
      exp_w[3] = 32'h000B_0005; exp_w[4] = 32'h0001_0001; exp_w[5] = 32'h001E_0A12;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cyc", {31'h0, bus.cyc}, 32'h0);
      check("rst_stb", {31'h0, bus.stb}, 32'h0);
      check("rst_we", {31'h0, bus.we}, 32'h0);
      check("rst_adr", bus.adr, 32'h0);
      check("rst_dat", bus.dat_w, 32'h0);
      check("rst_flags", {29'h0, busy, done, err}, 32'h0);
      check("rst_err_adr", err_adr, 32'h0);
      check("sel", {28'h0, bus.sel}, 32'hF);
      rst = 1'b0;
      @(negedge clk);

      // 1: full init sequence
      dly1 = 16'd2; dly2 = 16'd8; div_f = 16'h1e0a;
      gain_dir = {10'd1, 10'd5, 10'd1, 10'd3};
      gain_crs = {10'd1, 10'd11, 10'd1, 10'd7};
      mode1 = 2'b01; mode2 = 2'b10;
      w0 = wlog_adr.size();
      start = 1'b1;
      run_seq(100, 0, dc, nd, s08);
`ifdef WB_SWAP_CFG_READBACK_EN
      check("t1_done_cycle", dc, 36);
`else
      check("t1_done_cycle", dc, 18);
`endif
      check("t1_done_count", nd, 1);
      check("t1_nwrites", wlog_adr.size() - w0, 6);
      for (int i = 0; i < 6; i++) begin
         if (w0 + i < wlog_adr.size()) begin
            check($sformatf("t1_adr%0d", i), wlog_adr[w0+i], (i == 5) ? 32'h0 : 32'(4 * (i + 1)));
            check($sformatf("t1_dat%0d", i), wlog_dat[w0+i], exp_w[i]);
         end
      end
      check("t1_err", {31'h0, err}, 32'h0);

      // 2: mode update read-modify-write
      ctrl_ovr = 1'b1; ctrl_val = 32'h00FF_FF1E;
      mode1 = 2'b11; mode2 = 2'b00;
      w0 = wlog_adr.size(); r0 = rlog_adr.size();
      @(negedge clk);
      mode_upd = 1'b1;
      run_seq(100, 0, dc, nd, s08);
      check("t2_nreads", rlog_adr.size() - r0, 1);
      if (r0 < rlog_adr.size()) check("t2_rd_adr", rlog_adr[r0], 32'h0);
      check("t2_nwrites", wlog_adr.size() - w0, 1);
      if (w0 < wlog_adr.size()) begin
         check("t2_wr_adr", wlog_adr[w0], 32'h0);
         check("t2_wr_dat", wlog_dat[w0], 32'h00FF_FF06);
      end
      check("t2_done", nd, 1);
      ctrl_ovr = 1'b0;

      // 3: slave never acks on 0x08 -> timeout
      noack08 = 1'b1;
      @(negedge clk);
      start = 1'b1;
      run_seq(200, 0, dc, nd, s08);
      check("t3_stb_cycles", s08, 16);
      check("t3_cyc", {31'h0, bus.cyc}, 32'h0);
      check("t3_err", {31'h0, err}, 32'h1);
      check("t3_err_adr", err_adr, 32'h8);
      check("t3_no_done", nd, 0);
      noack08 = 1'b0;

      // 4: simultaneous start/mode_upd, then start while busy
      w0 = wlog_adr.size();
      @(negedge clk);
      start = 1'b1; mode_upd = 1'b1;
      run_seq(100, 5, dc, nd, s08);
      check("t4_err_cleared", {31'h0, err}, 32'h0);
      repeat (10) @(negedge clk);
      check("t4_nwrites", wlog_adr.size() - w0, 6);
      check("t4_done_count", nd, 1);
      check("t4_idle", {31'h0, busy}, 32'h0);
      if (w0 < wlog_adr.size()) check("t4_first_adr", wlog_adr[w0], 32'h4);

      // 5: reset during WAIT_ACK of the 3rd write
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (bus.stb && bus.we && bus.adr == 32'hC) break;
         @(negedge clk);
      end
      check("t5_reached_0c", bus.adr, 32'hC);
      rst = 1'b1;
      @(negedge clk);
      check("t5_cyc", {31'h0, bus.cyc}, 32'h0);
      check("t5_stb", {31'h0, bus.stb}, 32'h0);
      check("t5_flags", {29'h0, busy, done, err}, 32'h0);
      check("t5_adr", bus.adr, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      w0 = wlog_adr.size();
      start = 1'b1;
      run_seq(100, 0, dc, nd, s08);
      check("t5_nwrites", wlog_adr.size() - w0, 6);
      if (w0 < wlog_adr.size()) check("t5_first_adr", wlog_adr[w0], 32'h4);
      check("t5_done", nd, 1);

`ifdef WB_SWAP_CFG_READBACK_EN
      // 6: readback mismatch on 0x08
      corrupt08 = 1'b1;
      w0 = wlog_adr.size();
      @(negedge clk);
      start = 1'b1;
      run_seq(100, 0, dc, nd, s08);
      check("t6_err", {31'h0, err}, 32'h1);
      check("t6_err_adr", err_adr, 32'h8);
      check("t6_nwrites", wlog_adr.size() - w0, 2);
      check("t6_no_done", nd, 0);
      corrupt08 = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
